// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register in front of the EX-stage ALU bank.
// It captures decoded operands and resolves EX/MEM forwarding at capture time.
// It inserts a single bubble on a load-use hazard and holds on a downstream
// stall. A branch flush turns the next cycle into a bubble.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   id_*                          decoded instruction presented by ID
//   flush                         kill the ID instruction (redirect)
//   mem_stall                     downstream cannot accept; freeze the stage
//   fwd_ex_*, fwd_mem_*           forwarding sources from EX and MEM/WB
//   ex_valid, alu_a, alu_b,
//   ex_aluop, ex_rd, ex_wen,
//   ex_is_load                    registered instruction driven to the ALU bank
//   id_stall                      combinational; ID must hold its instruction
module ex_operand_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 5,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REGW-1:0]  id_rs,
  input  logic [REGW-1:0]  id_rt,
  input  logic [WIDTH-1:0] id_rs_val,
  input  logic [WIDTH-1:0] id_rt_val,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_use_imm,
  input  logic [OPW-1:0]   id_aluop,
  input  logic [REGW-1:0]  id_rd,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             mem_stall,
  input  logic             fwd_ex_wen,
  input  logic [REGW-1:0]  fwd_ex_rd,
  input  logic [WIDTH-1:0] fwd_ex_val,
  input  logic             fwd_mem_wen,
  input  logic [REGW-1:0]  fwd_mem_rd,
  input  logic [WIDTH-1:0] fwd_mem_val,
  output logic             ex_valid,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   ex_aluop,
  output logic [REGW-1:0]  ex_rd,
  output logic             ex_wen,
  output logic             ex_is_load,
  output logic             id_stall
);

  logic             load_use;
  logic [WIDTH-1:0] rs_fwd;
  logic [WIDTH-1:0] rt_fwd;
  logic [WIDTH-1:0] b_next;

  // A load in EX whose result is needed by ID cannot be forwarded in time.
  // rt only matters when B actually comes from the register file.
  always_comb begin
    load_use = id_valid & ex_valid & ex_is_load & ex_wen & (ex_rd != '0) &
               ((ex_rd == id_rs) | (!id_use_imm & (ex_rd == id_rt)));
  end

  // A flush discards the ID instruction, so ID never needs to hold it.
  assign id_stall = !flush & (mem_stall | load_use);

  // rs forwarding: EX beats MEM; r0 always reads the register file.
  always_comb begin
    rs_fwd = id_rs_val;
    if (fwd_ex_wen && (fwd_ex_rd == id_rs) && (id_rs != '0)) begin
      rs_fwd = fwd_ex_val;
    end else if (fwd_mem_wen && (fwd_mem_rd == id_rs) && (id_rs != '0)) begin
      rs_fwd = fwd_mem_val;
    end
  end

  // rt forwarding: same rules as rs.
  always_comb begin
    rt_fwd = id_rt_val;
    if (fwd_ex_wen && (fwd_ex_rd == id_rt) && (id_rt != '0)) begin
      rt_fwd = fwd_ex_val;
    end else if (fwd_mem_wen && (fwd_mem_rd == id_rt) && (id_rt != '0)) begin
      rt_fwd = fwd_mem_val;
    end
  end

  // B operand: the immediate bypasses forwarding entirely.
  always_comb begin
    b_next = id_use_imm ? id_imm : rt_fwd;
  end

  // Pipeline register: flush > mem_stall > load_use bubble > capture.
  // Bubbles clear only the control bits; data fields keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      ex_aluop   <= '0;
      ex_rd      <= '0;
      ex_wen     <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_wen     <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (!mem_stall) begin
      if (load_use) begin
        ex_valid   <= 1'b0;
        ex_wen     <= 1'b0;
        ex_is_load <= 1'b0;
      end else begin
        ex_valid   <= id_valid;
        alu_a      <= rs_fwd;
        alu_b      <= b_next;
        ex_aluop   <= id_aluop;
        ex_rd      <= id_rd;
        ex_wen     <= id_wen & id_valid;
        ex_is_load <= id_is_load & id_valid;
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed self-checking bench for ex_operand_stage.
// Inputs change 1ns after a rising edge. Registered outputs are checked 1ns
// after the following edge. id_stall is checked in the same cycle as the
// stimulus that causes it.
module tb_ex_operand_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned REGW  = 5;
  localparam int unsigned OPW   = 4;
  localparam logic [OPW-1:0] OP_AND = 4'h1;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [REGW-1:0]  id_rs;
  logic [REGW-1:0]  id_rt;
  logic [WIDTH-1:0] id_rs_val;
  logic [WIDTH-1:0] id_rt_val;
  logic [WIDTH-1:0] id_imm;
  logic             id_use_imm;
  logic [OPW-1:0]   id_aluop;
  logic [REGW-1:0]  id_rd;
  logic             id_wen;
  logic             id_is_load;
  logic             flush;
  logic             mem_stall;
  logic             fwd_ex_wen;
  logic [REGW-1:0]  fwd_ex_rd;
  logic [WIDTH-1:0] fwd_ex_val;
  logic             fwd_mem_wen;
  logic [REGW-1:0]  fwd_mem_rd;
  logic [WIDTH-1:0] fwd_mem_val;
  logic             ex_valid;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   ex_aluop;
  logic [REGW-1:0]  ex_rd;
  logic             ex_wen;
  logic             ex_is_load;
  logic             id_stall;

  int vectors;
  int miscompares;

  ex_operand_stage #(.WIDTH(WIDTH), .REGW(REGW), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_aluop(id_aluop), .id_rd(id_rd),
    .id_wen(id_wen), .id_is_load(id_is_load),
    .flush(flush), .mem_stall(mem_stall),
    .fwd_ex_wen(fwd_ex_wen), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_val(fwd_ex_val),
    .fwd_mem_wen(fwd_mem_wen), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_val(fwd_mem_val),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .ex_aluop(ex_aluop),
    .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .id_stall(id_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_valid = 0; id_rs = '0; id_rt = '0; id_rs_val = '0; id_rt_val = '0;
    id_imm = '0; id_use_imm = 0; id_aluop = '0; id_rd = '0; id_wen = 0;
    id_is_load = 0; flush = 0; mem_stall = 0;
    fwd_ex_wen = 0; fwd_ex_rd = '0; fwd_ex_val = '0;
    fwd_mem_wen = 0; fwd_mem_rd = '0; fwd_mem_val = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Places a load writing r7 into EX.
  task automatic load_r7_into_ex();
    idle();
    id_valid = 1; id_is_load = 1; id_wen = 1; id_rd = 5'd7;
    id_rs = 5'd1; id_rt = 5'd2; id_use_imm = 1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    vectors++;
    if ({ex_valid, ex_wen, ex_is_load, alu_a, alu_b, ex_aluop, ex_rd} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b wen=%b load=%b a=%h b=%h op=%h rd=%h required all 0",
               ex_valid, ex_wen, ex_is_load, alu_a, alu_b, ex_aluop, ex_rd);
    end
    rst = 0;
    tick();
    vectors++;
    if (ex_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_valid: got %b required 0", ex_valid);
    end
  endtask

  task automatic test_capture();
    idle();
    id_valid = 1; id_rs = 5'd3; id_rs_val = 32'h0000_00F0;
    id_rt = 5'd4; id_rt_val = 32'h0000_0F0F; id_aluop = OP_AND;
    id_rd = 5'd9; id_wen = 1;
    tick();
    vectors++;
    if (alu_a !== 32'h0000_00F0) begin
      miscompares++; $display("FAIL capture_a: got %h required 000000f0", alu_a);
    end
    vectors++;
    if (alu_b !== 32'h0000_0F0F) begin
      miscompares++; $display("FAIL capture_b: got %h required 00000f0f", alu_b);
    end
    vectors++;
    if ({ex_valid, ex_wen, ex_is_load, ex_aluop, ex_rd} !== {3'b110, OP_AND, 5'd9}) begin
      miscompares++;
      $display("FAIL capture_ctrl: valid=%b wen=%b load=%b op=%h rd=%0d required 1 1 0 1 9",
               ex_valid, ex_wen, ex_is_load, ex_aluop, ex_rd);
    end
    // Asynchronous reset between edges clears immediately.
    #2 rst = 1;
    #1;
    vectors++;
    if ({ex_valid, ex_wen, alu_a, alu_b, ex_aluop, ex_rd} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b wen=%b a=%h b=%h op=%h rd=%h required all 0",
               ex_valid, ex_wen, alu_a, alu_b, ex_aluop, ex_rd);
    end
    rst = 0;
    tick();
    // First edge after release captures normally.
    tick();
    vectors++;
    if (ex_valid !== 1'b1 || alu_a !== 32'h0000_00F0) begin
      miscompares++;
      $display("FAIL post_reset_capture: valid=%b a=%h required 1 000000f0", ex_valid, alu_a);
    end
  endtask

  task automatic test_forward();
    idle();
    id_valid = 1; id_rs = 5'd5; id_rs_val = 32'h0BAD_0BAD;
    id_rt = 5'd6; id_rt_val = 32'h0000_0066;
    fwd_ex_wen = 1; fwd_ex_rd = 5'd5; fwd_ex_val = 32'hAAAA_AAAA;
    fwd_mem_wen = 1; fwd_mem_rd = 5'd5; fwd_mem_val = 32'h5555_5555;
    tick();
    vectors++;
    if (alu_a !== 32'hAAAA_AAAA) begin
      miscompares++; $display("FAIL fwd_ex_priority: got %h required aaaaaaaa", alu_a);
    end
    vectors++;
    if (alu_b !== 32'h0000_0066) begin
      miscompares++; $display("FAIL fwd_rt_untouched: got %h required 00000066", alu_b);
    end
    fwd_ex_wen = 0;
    tick();
    vectors++;
    if (alu_a !== 32'h5555_5555) begin
      miscompares++; $display("FAIL fwd_mem: got %h required 55555555", alu_a);
    end
    // MEM forwarding on rt as well.
    fwd_mem_rd = 5'd6;
    tick();
    vectors++;
    if (alu_a !== 32'h0BAD_0BAD || alu_b !== 32'h5555_5555) begin
      miscompares++;
      $display("FAIL fwd_mem_rt: a=%h b=%h required 0bad0bad 55555555", alu_a, alu_b);
    end
    id_rs = 5'd0; id_rs_val = 32'hDEAD_BEEF;
    fwd_ex_wen = 1; fwd_ex_rd = 5'd0; fwd_mem_rd = 5'd0;
    tick();
    vectors++;
    if (alu_a !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL fwd_r0: got %h required deadbeef", alu_a);
    end
  endtask

  task automatic test_load_use();
    load_r7_into_ex();
    idle();
    id_valid = 1; id_rs = 5'd7; id_rt = 5'd8; id_rt_val = 32'h0000_0008;
    id_rd = 5'd10; id_wen = 1; id_aluop = OP_AND;
    #1;
    vectors++;
    if (id_stall !== 1'b1) begin
      miscompares++; $display("FAIL load_use_stall: got %b required 1", id_stall);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b0 || ex_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL load_use_bubble: valid=%b wen=%b required 0 0", ex_valid, ex_wen);
    end
    // Loaded value now in MEM/WB.
    fwd_mem_wen = 1; fwd_mem_rd = 5'd7; fwd_mem_val = 32'h1234_5678;
    #1;
    vectors++;
    if (id_stall !== 1'b0) begin
      miscompares++; $display("FAIL load_use_single_bubble: stall=%b required 0", id_stall);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b1 || alu_a !== 32'h1234_5678 || ex_rd !== 5'd10) begin
      miscompares++;
      $display("FAIL load_use_replay: valid=%b a=%h rd=%0d required 1 12345678 10",
               ex_valid, alu_a, ex_rd);
    end
    // rt matching the load is irrelevant when B is the immediate.
    load_r7_into_ex();
    idle();
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd7; id_use_imm = 1; id_imm = 32'h0000_0042;
    #1;
    vectors++;
    if (id_stall !== 1'b0) begin
      miscompares++; $display("FAIL load_use_imm_nostall: stall=%b required 0", id_stall);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b1 || alu_b !== 32'h0000_0042) begin
      miscompares++;
      $display("FAIL load_use_imm_capture: valid=%b b=%h required 1 00000042", ex_valid, alu_b);
    end
  endtask

  task automatic test_mem_stall();
    idle();
    id_valid = 1; id_rs = 5'd2; id_rs_val = 32'h0000_0011; id_rd = 5'd3; id_wen = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_stall = 1;
      id_rs_val = 32'h0000_0100 + 32'(i); id_rd = 5'(20 + i);
      #1;
      vectors++;
      if (id_stall !== 1'b1) begin
        miscompares++; $display("FAIL mem_stall_out[%0d]: got %b required 1", i, id_stall);
      end
      tick();
      vectors++;
      if (alu_a !== 32'h0000_0011 || ex_valid !== 1'b1 || ex_rd !== 5'd3) begin
        miscompares++;
        $display("FAIL mem_stall_hold[%0d]: a=%h valid=%b rd=%0d required 00000011 1 3",
                 i, alu_a, ex_valid, ex_rd);
      end
    end
    mem_stall = 0; id_rs_val = 32'h0000_0022; id_rd = 5'd4;
    tick();
    vectors++;
    if (alu_a !== 32'h0000_0022 || ex_rd !== 5'd4) begin
      miscompares++;
      $display("FAIL mem_stall_release: a=%h rd=%0d required 00000022 4", alu_a, ex_rd);
    end
    // mem_stall with load_use holds; the bubble follows once the stall drops.
    load_r7_into_ex();
    idle();
    id_valid = 1; id_rs = 5'd7; mem_stall = 1;
    #1;
    vectors++;
    if (id_stall !== 1'b1) begin
      miscompares++; $display("FAIL stall_and_hazard_out: got %b required 1", id_stall);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b1 || ex_is_load !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_and_hazard_hold: valid=%b load=%b required 1 1", ex_valid, ex_is_load);
    end
    mem_stall = 0;
    tick();
    vectors++;
    if (ex_valid !== 1'b0 || ex_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_then_bubble: valid=%b wen=%b required 0 0", ex_valid, ex_wen);
    end
  endtask

  task automatic test_flush();
    load_r7_into_ex();
    idle();
    id_valid = 1; id_rs = 5'd7; id_wen = 1; mem_stall = 1; flush = 1;
    #1;
    vectors++;
    if (id_stall !== 1'b0) begin
      miscompares++; $display("FAIL flush_stall_out: got %b required 0", id_stall);
    end
    tick();
    vectors++;
    if ({ex_valid, ex_wen, ex_is_load} !== 3'b000) begin
      miscompares++;
      $display("FAIL flush_bubble: valid=%b wen=%b load=%b required 0 0 0",
               ex_valid, ex_wen, ex_is_load);
    end
  endtask

  task automatic test_imm();
    idle();
    id_valid = 1; id_rs = 5'd1; id_rs_val = 32'h0000_0001;
    id_rt = 5'd6; id_rt_val = 32'h0000_0006;
    id_use_imm = 1; id_imm = 32'hFFFF_FF00;
    fwd_ex_wen = 1; fwd_ex_rd = 5'd6; fwd_ex_val = 32'hCAFE_F00D;
    tick();
    vectors++;
    if (alu_b !== 32'hFFFF_FF00 || alu_a !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL imm_path: a=%h b=%h required 00000001 ffffff00", alu_a, alu_b);
    end
  endtask

  task automatic test_invalid_bubble();
    idle();
    id_valid = 0; id_wen = 1; id_is_load = 1; id_rd = 5'd12;
    tick();
    vectors++;
    if ({ex_valid, ex_wen, ex_is_load} !== 3'b000) begin
      miscompares++;
      $display("FAIL invalid_no_ctrl: valid=%b wen=%b load=%b required 0 0 0",
               ex_valid, ex_wen, ex_is_load);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 0;
    idle();
    #1;
    test_reset();
    test_capture();
    test_forward();
    test_load_use();
    test_mem_stall();
    test_flush();
    test_imm();
    test_invalid_bubble();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
